// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM with retired-instruction counter
module mips_multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [2:0]          ula_operation,
  output logic [1:0]          PCSource,
  output logic [1:0]          BranchOp,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic                illegal
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = 1;

  state_t cur_state;
  state_t nxt_state;
  logic   retire_inc;

  assign state = cur_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= FETCH;
      retired   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (retire_inc) retired <= retired + RETIRE_ONE;
    end
  end

  always_comb begin
    PCWrite       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ula_operation = 3'b000;
    PCSource      = 2'b00;
    BranchOp      = 2'b00;
    illegal       = 1'b0;
    retire_inc    = 1'b0;
    nxt_state     = FETCH;
    case (cur_state)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        nxt_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes PC + (imm << 2) so BRANCH can use it directly
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   nxt_state = MEM_ADDR;
          OP_R:           nxt_state = R_EXEC;
          OP_BEQ, OP_BNE: nxt_state = BRANCH;
          OP_ADDI:        nxt_state = ADDI_EXEC;
          OP_J:           nxt_state = JUMP;
          default: begin
            illegal   = 1'b1;
            nxt_state = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nxt_state = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        retire_inc = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        retire_inc = mem_ready;
        nxt_state  = mem_ready ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        ALUSrcA       = 1'b1;
        ula_operation = 3'b010;
        nxt_state     = R_WB;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        retire_inc = 1'b1;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ula_operation = 3'b001;
        PCSource      = 2'b01;
        BranchOp      = (opcode == OP_BNE) ? 2'b10 : 2'b01;
        retire_inc    = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        retire_inc = 1'b1;
      end
      ADDI_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        retire_inc = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameter: RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 Port: clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous, active-high reset.
REQ-004 Port: opcode, input, 6, instruction[31:26] from the instruction register.
REQ-005 Port: mem_ready, input, 1, memory handshake; current access completes in a cycle where it is 1.
REQ-006 Port: PCWrite, output, 1, unconditional PC load.
REQ-007 Port: IorD, output, 1, memory address source: 0 PC, 1 ula_result.
REQ-008 Port: MemRead, output, 1, memory read request.
REQ-009 Port: MemWrite, output, 1, memory write request.
REQ-010 Port: IRWrite, output, 1, instruction register load.
REQ-011 Port: MemtoReg, output, 1, register write data: 1 memory data, 0 ula_result.
REQ-012 Port: RegDst, output, 1, write register: 1 instruction[15:11], 0 instruction[20:16].
REQ-013 Port: RegWrite, output, 1, regfile write enable.
REQ-014 Port: ALUSrcA, output, 1, ULA In1: 0 PC, 1 ReadData1.
REQ-015 Port: ALUSrcB, output, 2, ULA In2: 00 ReadData2, 01 constant 4, 10 sign-extend, 11 sign-extend<<2.
REQ-016 Port: ula_operation, output, 3, to ula_control: 000 add, 001 sub, 010 decode funct.
REQ-017 Port: PCSource, output, 2, PC input: 00 ULA result, 01 branch-target register, 10 jump target.
REQ-018 Port: BranchOp, output, 2, to branch module: 00 none, 01 beq, 10 bne.
REQ-019 Port: state, output, 4, current FSM state encoding.
REQ-020 Port: retired, output, RETIRE_W, count of completed instructions.
REQ-021 Port: illegal, output, 1, one-cycle pulse on an unsupported opcode.

Function
REQ-022 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
REQ-023 States SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; codes 12-15 unused.
REQ-024 Any output not named for a state SHALL be 0 in that state; outputs SHALL be decoded from state, plus mem_ready where stated.
REQ-025 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ula_operation=000; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-026 DECODE: ALUSrcA=0, ALUSrcB=11, ula_operation=000 (branch target computed).
REQ-027 DECODE next state: lw/sw->MEM_ADDR, R->R_EXEC, beq/bne->BRANCH, addi->ADDI_EXEC, j->JUMP.
REQ-028 DECODE with an unsupported opcode: next state FETCH, illegal=1 for that DECODE cycle, retired unchanged.
REQ-029 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ula_operation=000; lw->MEM_READ, sw->MEM_WRITE.
REQ-030 MEM_READ: MemRead=1, IorD=1; wait on mem_ready=0, else go to MEM_WB.
REQ-031 MEM_WRITE: MemWrite=1, IorD=1; wait on mem_ready=0, else go to FETCH.
REQ-032 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-033 R_EXEC: ALUSrcA=1, ALUSrcB=00, ula_operation=010; then R_WB.
REQ-034 R_WB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
REQ-035 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ula_operation=000; then ADDI_WB.
REQ-036 ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
REQ-037 BRANCH: ALUSrcA=1, ALUSrcB=00, ula_operation=001, PCSource=01, BranchOp=01 (beq) or 10 (bne); then FETCH.
REQ-038 JUMP: PCWrite=1, PCSource=10; then FETCH.
REQ-039 The opcode SHALL be sampled in every state; the instruction register holds it stable after FETCH.
REQ-040 retired SHALL increment by 1 on the edge leaving MEM_WB, MEM_WRITE (only with mem_ready=1), R_WB, ADDI_WB, BRANCH, or JUMP.
REQ-041 retired SHALL wrap from all-ones to 0 silently.
REQ-042 Latency SHALL be, with mem_ready tied to 1: lw 5 cycles; R, addi and sw 4 cycles; beq, bne and j 3 cycles.
REQ-043 An unused state code SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-044 reset=1 SHALL immediately force state=FETCH and retired=0, including mid-instruction or mid-handshake; no partial write completes after assertion.
REQ-045 After reset release, the first rising edge SHALL evaluate FETCH normally; FETCH outputs are visible during reset.

Verification
REQ-046 Scenario: reset, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; RegWrite=1 only in state 7; retired=1.
REQ-047 Scenario: lw opcode, mem_ready low for 3 cycles in MEM_READ -> state 3 held for 4 cycles; then 4,0; retired increments once.
REQ-048 Scenario: bne opcode -> state 8 with BranchOp=10, ula_operation=001, PCSource=01; back to 0 after 3 cycles.
REQ-049 Scenario: opcode=111111 -> illegal pulses for 1 cycle in DECODE; next state 0; retired unchanged.
REQ-050 Scenario: reset asserted in MEM_WRITE with mem_ready=0 -> MemWrite drops without a clock edge; state=0; retired=0.
REQ-051 Scenario: RETIRE_W=4, 16 j instructions -> retired wraps 15->0.
